// File: rtl/gbc_reg_pkg.sv
// Shared register-file definitions: register codes, operation codes, pair codes
// and the pair-to-byte-register lookups used by the sequencer, register file and decoder.
package gbc_reg_pkg;

    typedef enum logic [2:0] {
        REG_B      = 3'b000,
        REG_C      = 3'b001,
        REG_D      = 3'b010,
        REG_E      = 3'b011,
        REG_H      = 3'b100,
        REG_L      = 3'b101,
        REG_HL_IND = 3'b110,
        REG_A      = 3'b111
    } reg_code_e;

    typedef enum logic [2:0] {
        OP_RD8  = 3'b000,
        OP_WR8  = 3'b001,
        OP_RD16 = 3'b010,
        OP_WR16 = 3'b011,
        OP_MOV8 = 3'b100
    } reg_op_e;

    typedef enum logic [1:0] {
        PAIR_BC = 2'b00,
        PAIR_DE = 2'b01,
        PAIR_HL = 2'b10
    } reg_pair_e;

    // Largest supported read latency of the register file
    localparam int RD_LAT_MAX = 2;

    // High byte register of a pair (B, D or H)
    function automatic reg_code_e pair_hi(input logic [1:0] pair);
        case (pair)
            PAIR_BC: pair_hi = REG_B;
            PAIR_DE: pair_hi = REG_D;
            default: pair_hi = REG_H;
        endcase
    endfunction

    // Low byte register of a pair (C, E or L)
    function automatic reg_code_e pair_lo(input logic [1:0] pair);
        case (pair)
            PAIR_BC: pair_lo = REG_C;
            PAIR_DE: pair_lo = REG_E;
            default: pair_lo = REG_L;
        endcase
    endfunction

endpackage

// File: rtl/reg_access_sequencer.sv
// Register-file access sequencer: expands one 8/16-bit read, write or move request
// into single-byte register-file accesses and returns one response per request.
module reg_access_sequencer
    import gbc_reg_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [2:0]  req_op_i,
    input  logic [2:0]  req_dst_i,
    input  logic [2:0]  req_src_i,
    input  logic [15:0] req_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        regEn_o,
    output logic        regRW_o,
    output logic [2:0]  regSel_o,
    output logic [7:0]  regDin_o,
    input  logic [7:0]  regDout_i
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ACC1  = 3'd1;
    localparam logic [2:0] S_WAIT1 = 3'd2;
    localparam logic [2:0] S_ACC2  = 3'd3;
    localparam logic [2:0] S_WAIT2 = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    localparam bit         HAS_WAIT  = (RD_LAT > 0);
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT > 0 ? RD_LAT - 1 : 0);

    if (RD_LAT < 0 || RD_LAT > RD_LAT_MAX) begin : g_rd_lat_check
        $error("reg_access_sequencer: RD_LAT out of range");
    end

    logic [2:0]  state, state_nxt;
    logic [2:0]  op_q, dst_q, src_q;
    logic [15:0] data_q;
    logic        err_q;
    logic [1:0]  wcnt;

    logic        req_err;
    logic        acc_en, acc_rw;
    logic [2:0]  acc_sel;
    logic [7:0]  acc_din;
    logic        cap, cap_hi;

    // Reject illegal ops and any register or pair code the op would actually use
    always_comb begin
        req_err = 1'b0;
        case (req_op_i)
            OP_RD8, OP_WR8:   req_err = (req_dst_i == REG_HL_IND);
            OP_RD16, OP_WR16: req_err = (req_dst_i[1:0] == 2'b11);
            OP_MOV8:          req_err = (req_dst_i == REG_HL_IND) || (req_src_i == REG_HL_IND);
            default:          req_err = 1'b1;
        endcase
    end

    // Access strobes for the current byte access; everything low outside ACC states
    always_comb begin
        acc_en  = 1'b0;
        acc_rw  = 1'b0;
        acc_sel = 3'b000;
        acc_din = 8'h00;
        if (state == S_ACC1) begin
            acc_en = 1'b1;
            case (op_q)
                OP_RD8:  acc_sel = dst_q;
                OP_WR8:  begin acc_sel = dst_q; acc_rw = 1'b1; acc_din = data_q[7:0]; end
                OP_RD16: acc_sel = pair_hi(dst_q[1:0]);
                OP_WR16: begin acc_sel = pair_hi(dst_q[1:0]); acc_rw = 1'b1; acc_din = data_q[15:8]; end
                default: acc_sel = src_q;
            endcase
        end else if (state == S_ACC2) begin
            acc_en = 1'b1;
            case (op_q)
                OP_RD16: acc_sel = pair_lo(dst_q[1:0]);
                OP_WR16: begin acc_sel = pair_lo(dst_q[1:0]); acc_rw = 1'b1; acc_din = data_q[7:0]; end
                default: begin acc_sel = dst_q; acc_rw = 1'b1; acc_din = data_q[7:0]; end
            endcase
        end
    end

    // Read byte is sampled on the last wait cycle, or on the read cycle itself with no latency
    always_comb begin
        if (HAS_WAIT) cap = ((state == S_WAIT1) || (state == S_WAIT2)) && (wcnt == 2'd0);
        else          cap = acc_en && !acc_rw;
        cap_hi = (op_q == OP_RD16) && ((state == S_ACC1) || (state == S_WAIT1));
    end

    // Next-state sequencing through access and wait phases
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_valid_i) state_nxt = req_err ? S_RESP : S_ACC1;
            S_ACC1: begin
                if (!acc_rw && HAS_WAIT)                     state_nxt = S_WAIT1;
                else if (op_q == OP_RD8 || op_q == OP_WR8)   state_nxt = S_RESP;
                else                                         state_nxt = S_ACC2;
            end
            S_WAIT1: if (wcnt == 2'd0) state_nxt = (op_q == OP_RD8) ? S_RESP : S_ACC2;
            S_ACC2:  state_nxt = (!acc_rw && HAS_WAIT) ? S_WAIT2 : S_RESP;
            S_WAIT2: if (wcnt == 2'd0) state_nxt = S_RESP;
            S_RESP:  if (rsp_ready_i) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, captured request and wait counter
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= S_IDLE;
            op_q  <= 3'b000;
            dst_q <= 3'b000;
            src_q <= 3'b000;
            err_q <= 1'b0;
            wcnt  <= 2'd0;
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && req_valid_i) begin
                op_q  <= req_op_i;
                dst_q <= req_dst_i;
                src_q <= req_src_i;
                err_q <= req_err;
            end
            if (state_nxt == S_WAIT1 || state_nxt == S_WAIT2) begin
                wcnt <= (state == S_WAIT1 || state == S_WAIT2) ? wcnt - 2'd1 : WAIT_INIT;
            end
        end
    end

    // Data register: write data on accept, read bytes on capture cycles
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q <= 16'h0000;
        end else if (state == S_IDLE && req_valid_i) begin
            if (req_err)                  data_q <= 16'h0000;
            else if (req_op_i == OP_WR16) data_q <= req_data_i;
            else if (req_op_i == OP_WR8)  data_q <= {8'h00, req_data_i[7:0]};
            else                          data_q <= 16'h0000;
        end else if (cap) begin
            if (cap_hi) data_q[15:8] <= regDout_i;
            else        data_q[7:0]  <= regDout_i;
        end
    end

    assign req_ready_o = (state == S_IDLE) && !rst_i;
    assign rsp_valid_o = (state == S_RESP);
    assign rsp_data_o  = rsp_valid_o ? data_q : 16'h0000;
    assign rsp_err_o   = rsp_valid_o && err_q;
    assign regEn_o     = acc_en;
    assign regRW_o     = acc_rw;
    assign regSel_o    = acc_sel;
    assign regDin_o    = acc_din;

endmodule

// File: tb/tb_reg_access_sequencer.sv
// Bench for reg_access_sequencer: three instances (RD_LAT 0, 1, 2), each with its own
// register-file environment, checked against a per-instance register model.
module tb_reg_access_sequencer;

    typedef struct {
        int         cyc;
        logic [2:0] sel;
        logic       rw;
        logic [7:0] din;
    } acc_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid, req_ready, rsp_valid, rsp_ready, rsp_err, reg_en, reg_rw;
    logic [2:0]  req_op [3];
    logic [2:0]  req_dst [3];
    logic [2:0]  req_src [3];
    logic [2:0]  reg_sel [3];
    logic [15:0] req_data [3];
    logic [15:0] rsp_data [3];
    logic [7:0]  reg_din [3];

    logic [7:0]  model_rf [3][8];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [7:0] rf [8];
        logic [7:0] dout, junk;
        logic [7:0] pd [2];
        logic [1:0] pv;

        reg_access_sequencer #(.RD_LAT(g)) u_dut (
            .clk_i(clk), .rst_i(rst),
            .req_valid_i(req_valid[g]), .req_ready_o(req_ready[g]),
            .req_op_i(req_op[g]), .req_dst_i(req_dst[g]), .req_src_i(req_src[g]),
            .req_data_i(req_data[g]),
            .rsp_valid_o(rsp_valid[g]), .rsp_ready_i(rsp_ready[g]),
            .rsp_data_o(rsp_data[g]), .rsp_err_o(rsp_err[g]),
            .regEn_o(reg_en[g]), .regRW_o(reg_rw[g]), .regSel_o(reg_sel[g]),
            .regDin_o(reg_din[g]), .regDout_i(dout)
        );

        always @(posedge clk) begin
            junk <= 8'($urandom);
            if (reg_en[g] && reg_rw[g]) rf[reg_sel[g]] <= reg_din[g];
            pv[0] <= reg_en[g] && !reg_rw[g];
            pd[0] <= rf[reg_sel[g]];
            pv[1] <= pv[0];
            pd[1] <= pd[0];
        end

        if (g == 0) begin : g_l0
            assign dout = (reg_en[g] && !reg_rw[g]) ? rf[reg_sel[g]] : junk;
        end else begin : g_ln
            assign dout = pv[g-1] ? pd[g-1] : junk;
        end
    end

    function automatic logic [7:0] get_rf(input int k, input int idx);
        case (k)
            0:       return g_dut[0].rf[idx];
            1:       return g_dut[1].rf[idx];
            default: return g_dut[2].rf[idx];
        endcase
    endfunction

    // One complete request/response transaction with full checking against the model
    task automatic do_op(input int k, input logic [2:0] op, input logic [2:0] dst,
                         input logic [2:0] src, input logic [15:0] data, input int hold);
        acc_t       exp_q[$];
        acc_t       got_q[$];
        acc_t       a;
        int         exp_lat, lat, w, hi, lo;
        logic [15:0] exp_data;
        logic       exp_err, legal;
        logic [7:0] v;

        legal = (op <= 3'd4);
        if ((op == 3'd0 || op == 3'd1) && dst == 3'd6) legal = 1'b0;
        if ((op == 3'd2 || op == 3'd3) && dst[1:0] == 2'd3) legal = 1'b0;
        if (op == 3'd4 && (dst == 3'd6 || src == 3'd6)) legal = 1'b0;
        hi = 2 * int'(dst[1:0]);
        lo = hi + 1;
        exp_err = !legal;
        exp_data = 16'h0000;
        exp_lat = 1;
        if (legal) begin
            case (op)
                3'd0: begin
                    exp_q.push_back('{1, dst, 1'b0, 8'h00});
                    exp_lat = 2 + k;
                    exp_data = {8'h00, model_rf[k][dst]};
                end
                3'd1: begin
                    exp_q.push_back('{1, dst, 1'b1, data[7:0]});
                    exp_lat = 2;
                    exp_data = {8'h00, data[7:0]};
                    model_rf[k][dst] = data[7:0];
                end
                3'd2: begin
                    exp_q.push_back('{1, 3'(hi), 1'b0, 8'h00});
                    exp_q.push_back('{2 + k, 3'(lo), 1'b0, 8'h00});
                    exp_lat = 3 + 2 * k;
                    exp_data = {model_rf[k][hi], model_rf[k][lo]};
                end
                3'd3: begin
                    exp_q.push_back('{1, 3'(hi), 1'b1, data[15:8]});
                    exp_q.push_back('{2, 3'(lo), 1'b1, data[7:0]});
                    exp_lat = 3;
                    exp_data = data;
                    model_rf[k][hi] = data[15:8];
                    model_rf[k][lo] = data[7:0];
                end
                default: begin
                    v = model_rf[k][src];
                    exp_q.push_back('{1, src, 1'b0, 8'h00});
                    exp_q.push_back('{2 + k, dst, 1'b1, v});
                    exp_lat = 3 + k;
                    exp_data = {8'h00, v};
                    model_rf[k][dst] = v;
                end
            endcase
        end

        w = 0;
        while (!req_ready[k] && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (req_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL ready_wait k=%0d got %b want 1", k, req_ready[k]);
            return;
        end
        req_valid[k] = 1'b1;
        req_op[k] = op;
        req_dst[k] = dst;
        req_src[k] = src;
        req_data[k] = data;
        @(posedge clk);
        #1;
        req_op[k] = 3'($urandom);
        req_dst[k] = 3'($urandom);
        req_src[k] = 3'($urandom);
        req_data[k] = 16'($urandom);

        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (reg_en[k]) begin
                got_q.push_back('{n, reg_sel[k], reg_rw[k], reg_din[k]});
                if (!reg_rw[k]) begin
                    checks++;
                    if (reg_din[k] !== 8'h00) begin
                        errors++;
                        $display("FAIL din_on_read k=%0d got %h want 00", k, reg_din[k]);
                    end
                end
            end else begin
                checks++;
                if (reg_rw[k] !== 1'b0 || reg_din[k] !== 8'h00 || reg_sel[k] === 3'bxxx) begin
                    errors++;
                    $display("FAIL idle_strobes k=%0d got rw=%b din=%h want 0/00", k, reg_rw[k], reg_din[k]);
                end
            end
            if (rsp_valid[k]) begin
                lat = n;
                break;
            end
        end
        req_valid[k] = 1'b0;

        checks++;
        if (lat !== exp_lat) begin
            errors++;
            $display("FAIL rsp_latency k=%0d op=%0d got %0d want %0d", k, op, lat, exp_lat);
        end
        checks++;
        if (rsp_data[k] !== exp_data || rsp_err[k] !== exp_err) begin
            errors++;
            $display("FAIL rsp k=%0d op=%0d got data=%h err=%b want data=%h err=%b",
                     k, op, rsp_data[k], rsp_err[k], exp_data, exp_err);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL access_count k=%0d op=%0d got %0d want %0d", k, op, got_q.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                a = got_q[i];
                checks++;
                if (a.cyc != exp_q[i].cyc || a.sel !== exp_q[i].sel || a.rw !== exp_q[i].rw || a.din !== exp_q[i].din) begin
                    errors++;
                    $display("FAIL access k=%0d op=%0d #%0d got cyc=%0d sel=%0d rw=%b din=%h want cyc=%0d sel=%0d rw=%b din=%h",
                             k, op, i, a.cyc, a.sel, a.rw, a.din, exp_q[i].cyc, exp_q[i].sel, exp_q[i].rw, exp_q[i].din);
                end
            end
        end
        if (lat == 0) return;

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (rsp_valid[k] !== 1'b1 || rsp_data[k] !== exp_data || rsp_err[k] !== exp_err ||
                reg_en[k] !== 1'b0 || req_ready[k] !== 1'b0) begin
                errors++;
                $display("FAIL rsp_hold k=%0d got v=%b d=%h e=%b en=%b rdy=%b want 1/%h/%b/0/0",
                         k, rsp_valid[k], rsp_data[k], rsp_err[k], reg_en[k], req_ready[k], exp_data, exp_err);
            end
        end
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        checks++;
        if (rsp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1 || rsp_data[k] !== 16'h0000) begin
            errors++;
            $display("FAIL resp_exit k=%0d got v=%b rdy=%b d=%h want 0/1/0000", k, rsp_valid[k], req_ready[k], rsp_data[k]);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = '0;
        rsp_ready = '0;
        for (int k = 0; k < 3; k++) begin
            req_op[k] = '0; req_dst[k] = '0; req_src[k] = '0; req_data[k] = '0;
        end
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready[k] !== 1'b0 || rsp_valid[k] !== 1'b0 || rsp_data[k] !== 16'h0 || rsp_err[k] !== 1'b0 ||
                reg_en[k] !== 1'b0 || reg_rw[k] !== 1'b0 || reg_sel[k] !== 3'b0 || reg_din[k] !== 8'h0) begin
                errors++;
                $display("FAIL reset_outputs k=%0d got rdy=%b v=%b d=%h e=%b en=%b rw=%b sel=%0d din=%h want all 0",
                         k, req_ready[k], rsp_valid[k], rsp_data[k], rsp_err[k], reg_en[k], reg_rw[k], reg_sel[k], reg_din[k]);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (req_ready[k] !== 1'b1) begin
                errors++;
                $display("FAIL idle_ready k=%0d got %b want 1", k, req_ready[k]);
            end
        end
    endtask

    task automatic test_preload(input int k);
        for (int r = 0; r < 8; r++) begin
            if (r != 6) do_op(k, 3'd1, 3'(r), 3'd0, 16'($urandom), 0);
        end
    endtask

    task automatic test_directed(input int k);
        do_op(k, 3'd1, 3'd7, 3'd0, 16'h005A, 0);
        do_op(k, 3'd0, 3'd7, 3'd0, 16'h0000, 0);
        do_op(k, 3'd3, 3'd2, 3'd0, 16'hBEEF, 0);
        do_op(k, 3'd2, 3'd2, 3'd0, 16'h0000, 0);
        do_op(k, 3'd1, 3'd1, 3'd0, 16'h0012, 0);
        do_op(k, 3'd4, 3'd3, 3'd1, 16'h0000, 0);
        do_op(k, 3'd0, 3'd3, 3'd0, 16'h0000, 0);
        do_op(k, 3'd4, 3'd5, 3'd5, 16'h0000, 1);
    endtask

    task automatic test_errors(input int k);
        do_op(k, 3'd0, 3'd6, 3'd0, 16'h1111, 0);
        do_op(k, 3'd2, 3'd3, 3'd0, 16'h2222, 0);
        do_op(k, 3'd7, 3'd0, 3'd0, 16'h3333, 0);
        do_op(k, 3'd4, 3'd0, 3'd6, 16'h4444, 0);
        do_op(k, 3'd3, 3'd7, 3'd0, 16'h5555, 2);
    endtask

    task automatic test_back_to_back(input int k);
        do_op(k, 3'd0, 3'd7, 3'd0, 16'h0000, 5);
        do_op(k, 3'd2, 3'd0, 3'd0, 16'h0000, 0);
        do_op(k, 3'd3, 3'd1, 3'd0, 16'hA55A, 0);
    endtask

    task automatic test_random(input int k);
        for (int i = 0; i < 30; i++) begin
            do_op(k, 3'($urandom_range(0, 5)), 3'($urandom), 3'($urandom), 16'($urandom), $urandom_range(0, 3));
        end
    endtask

    task automatic test_mid_reset(input int k);
        logic [7:0] c_old;
        c_old = model_rf[k][1];
        req_valid[k] = 1'b1;
        req_op[k] = 3'd3;
        req_dst[k] = 3'd0;
        req_data[k] = 16'h1234;
        @(posedge clk);
        #1;
        req_valid[k] = 1'b0;
        @(negedge clk);
        checks++;
        if (reg_en[k] !== 1'b1 || reg_sel[k] !== 3'd0 || reg_din[k] !== 8'h12) begin
            errors++;
            $display("FAIL mid_acc1 k=%0d got en=%b sel=%0d din=%h want 1/0/12", k, reg_en[k], reg_sel[k], reg_din[k]);
        end
        @(negedge clk);
        checks++;
        if (reg_en[k] !== 1'b1 || reg_sel[k] !== 3'd1 || reg_din[k] !== 8'h34) begin
            errors++;
            $display("FAIL mid_acc2 k=%0d got en=%b sel=%0d din=%h want 1/1/34", k, reg_en[k], reg_sel[k], reg_din[k]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (req_ready[k] !== 1'b0 || rsp_valid[k] !== 1'b0 || rsp_data[k] !== 16'h0 || rsp_err[k] !== 1'b0 ||
            reg_en[k] !== 1'b0 || reg_rw[k] !== 1'b0 || reg_sel[k] !== 3'b0 || reg_din[k] !== 8'h0) begin
            errors++;
            $display("FAIL mid_reset_outputs k=%0d got rdy=%b v=%b en=%b rw=%b sel=%0d din=%h want all 0",
                     k, req_ready[k], rsp_valid[k], reg_en[k], reg_rw[k], reg_sel[k], reg_din[k]);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_rf[k][0] = 8'h12;
        checks++;
        if (get_rf(k, 0) !== 8'h12 || get_rf(k, 1) !== c_old) begin
            errors++;
            $display("FAIL mid_reset_regs k=%0d got B=%h C=%h want B=12 C=%h", k, get_rf(k, 0), get_rf(k, 1), c_old);
        end
        @(negedge clk);
        checks++;
        if (req_ready[k] !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_ready k=%0d got %b want 1", k, req_ready[k]);
        end
        do_op(k, 3'd2, 3'd0, 3'd0, 16'h0000, 0);
    endtask

    initial begin
        test_reset();
        for (int k = 0; k < 3; k++) begin
            test_preload(k);
            test_directed(k);
            test_errors(k);
            test_back_to_back(k);
            test_random(k);
            test_mid_reset(k);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
